// File: rtl/serial_feeder.sv
// serial_feeder
// Parallel-to-serial front end for the pattern-detector path. Words arrive over
// a valid/ready handshake and leave one bit per clock on serial_out. A one-word
// holding register lets the next word wait while the current one is shifting,
// so consecutive words form one continuous bit stream.
//
// Parameters:
//   WIDTH      word width in bits (at least 2)
//   MSB_FIRST  1 = shift bit WIDTH-1 out first, 0 = shift bit 0 out first
//   IDLE_BIT   level driven on serial_out when no word is being shifted
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   data_in      word to serialise, sampled on accept
//   data_valid   producer has a word on data_in
//   data_ready   block can accept a word this cycle
//   serial_out   registered serial stream (detector input I)
//   bit_valid    serial_out carries a data bit rather than idle fill
//   frame_start  high while the first bit of a word is on serial_out
//   busy         shifting in progress or holding register occupied
module serial_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             accept;

  // Moves the next bit into the head position of the shift register.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end else begin
      return v[0];
    end
  endfunction

  // Ready depends only on registered state, plus reset so nothing is taken
  // while the block is being cleared.
  assign data_ready = !hold_full_q && !reset;
  assign accept     = data_valid && data_ready;

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      hold_q        <= '0;
      cnt_q         <= '0;
      hold_full_q   <= 1'b0;
      serial_out_q  <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      hold_full_q   <= hold_full_d;
      serial_out_q  <= serial_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state logic. On the last bit of a word the holding register takes
  // priority over a new accept; an accept there is impossible anyway because
  // data_ready is low while hold is full. Outputs are derived from the next
  // state so they line up with the word position after the edge.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          sr_d  = advance(sr_q);
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          sr_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word arriving exactly on the last bit goes straight to sr.
          sr_d  = data_in;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    serial_out_d  = (state_d == SHIFT) ? head_bit(sr_d) : IDLE_BIT;
    bit_valid_d   = (state_d == SHIFT);
    frame_start_d = (state_d == SHIFT) && (cnt_d == '0);
  end

  assign serial_out  = serial_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == SHIFT) || hold_full_q;

endmodule
